fetch_ctrl: RTL and testbench

//   Instruction fetch controller: owns the PC register and issues reads to a variable-latency

---
 rtl/fetch_if.sv | 29 ++
 rtl/fetch_ctrl.sv | 84 ++++++++
 tb/tb_fetch_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
`default_nettype none
// =============================================================================
// fetch_if : instruction-memory and decode-stage handshake bundle for fetch_ctrl
// Revision : 1.0
// =============================================================================
interface fetch_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] PC;
  logic [15:0] PC_nxt;
  logic        halt;
  logic        err;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, PC, err,
    input  imem_ack, imem_rdata, instr_ready, PC_nxt, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, PC, err,
    output imem_ack, imem_rdata, instr_ready, PC_nxt, halt
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// =============================================================================
// fetch_ctrl : PC owner, variable-latency imem fetch, valid/ready decode handoff
// Revision   : 1.0
// =============================================================================
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  wire logic clk,
  input  wire logic rst,
  fetch_if.master   bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_VALID = 3'd2,
    S_HALT  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      state, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  count, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      count   <= 8'd0;
    end else begin
      state   <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count   <= count_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count;
    case (state)
      // One quiet cycle so an ack left over from an abandoned request is never taken.
      S_IDLE: state_d = pc_q[0] ? S_ERR : S_REQ;
      S_REQ: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          count_d = 8'd0;
          state_d = S_VALID;
        end else if (count == TIMEOUT_CNT) begin
          state_d = S_ERR;
        end else begin
          count_d = count + 8'd1;
        end
      end
      S_VALID: begin
        if (bus.instr_ready) begin
          pc_d = bus.PC_nxt;
          if (bus.halt)           state_d = S_HALT;
          else if (bus.PC_nxt[0]) state_d = S_ERR;
          else                    state_d = S_REQ;
        end
      end
      default: state_d = state;
    endcase
  end

  // Handshake outputs decode registered state only.
  assign bus.imem_req    = (state == S_REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state == S_VALID);
  assign bus.PC          = pc_q;
  assign bus.err         = (state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// =============================================================================
// tb_fetch_ctrl : self-checking bench for fetch_ctrl with transaction-level model
// Revision      : 1.0
// =============================================================================
module tb_fetch_ctrl;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          TIMEOUT  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b0;
    bus.halt = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Memory answers after lat unacked cycles.
  task automatic serve(input int lat, input logic [15:0] data);
    bus.imem_ack = 1'b0;
    for (int i = 0; i < lat; i++) tick();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = data;
    tick();
    bus.imem_ack = 1'b0;
  endtask

  task automatic retire(input logic [15:0] nxt, input logic h);
    bus.instr_ready = 1'b1;
    bus.PC_nxt = nxt;
    bus.halt = h;
    tick();
    bus.instr_ready = 1'b0;
    bus.halt = 1'b0;
  endtask

  task automatic test_reset();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 16'hDEAD;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({bus.imem_req, bus.instr_valid, bus.err, bus.PC, bus.instr} !== {3'b000, RESET_PC, 16'h0000}) begin
      $display("FAIL reset_state: got req/val/err=%b PC=%h instr=%h, expected 000 PC=%h instr=0000",
               {bus.imem_req, bus.instr_valid, bus.err}, bus.PC, bus.instr, RESET_PC);
    end else passed++;
    // Stale ack during the idle cycle must be ignored.
    tick();
    bus.imem_ack = 1'b0;
    total++;
    if ({bus.imem_req, bus.instr_valid, bus.imem_addr} !== {2'b10, RESET_PC}) begin
      $display("FAIL reset_first_req: got req/val=%b addr=%h, expected 10 addr=%h",
               {bus.imem_req, bus.instr_valid}, bus.imem_addr, RESET_PC);
    end else passed++;
  endtask

  task automatic test_min_latency();
    logic [15:0] exp_pc, d;
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      exp_pc = RESET_PC + 16'(2 * i);
      total++;
      if ({bus.imem_req, bus.instr_valid, bus.err, bus.imem_addr} !== {3'b100, exp_pc}) begin
        $display("FAIL minlat_req[%0d]: got req/val/err=%b addr=%h, expected 100 addr=%h",
                 i, {bus.imem_req, bus.instr_valid, bus.err}, bus.imem_addr, exp_pc);
      end else passed++;
      d = 16'($urandom);
      bus.imem_ack = 1'b1;
      bus.imem_rdata = d;
      tick();
      bus.imem_ack = 1'b0;
      total++;
      if ({bus.imem_req, bus.instr_valid, bus.err, bus.instr} !== {3'b010, d}) begin
        $display("FAIL minlat_valid[%0d]: got req/val/err=%b instr=%h, expected 010 instr=%h",
                 i, {bus.imem_req, bus.instr_valid, bus.err}, bus.instr, d);
      end else passed++;
      retire(exp_pc + 16'd2, 1'b0);
    end
  endtask

  task automatic test_latency3();
    do_reset();
    tick();
    serve(0, 16'h1111);
    retire(16'h0002, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      total++;
      if ({bus.imem_req, bus.instr_valid, bus.imem_addr} !== {2'b10, 16'h0002}) begin
        $display("FAIL lat3_wait[%0d]: got req/val=%b addr=%h, expected 10 addr=0002",
                 k, {bus.imem_req, bus.instr_valid}, bus.imem_addr);
      end else passed++;
      if (k == 3) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h4125;
      end
      tick();
      bus.imem_ack = 1'b0;
    end
    total++;
    if ({bus.imem_req, bus.instr_valid, bus.instr} !== {2'b01, 16'h4125}) begin
      $display("FAIL lat3_valid: got req/val=%b instr=%h, expected 01 instr=4125",
               {bus.imem_req, bus.instr_valid}, bus.instr);
    end else passed++;
  endtask

  // Continues from the held 0x4125 instruction at PC 0x0002.
  task automatic test_backpressure();
    for (int k = 0; k < 5; k++) begin
      bus.instr_ready = 1'b0;
      bus.imem_ack = 1'($urandom);
      bus.imem_rdata = 16'($urandom);
      tick();
      total++;
      if ({bus.imem_req, bus.instr_valid, bus.err, bus.instr, bus.PC} !== {3'b010, 16'h4125, 16'h0002}) begin
        $display("FAIL backpressure[%0d]: got req/val/err=%b instr=%h PC=%h, expected 010 4125 0002",
                 k, {bus.imem_req, bus.instr_valid, bus.err}, bus.instr, bus.PC);
      end else passed++;
    end
    bus.imem_ack = 1'b0;
    retire(16'h0004, 1'b0);
    total++;
    if ({bus.imem_req, bus.instr_valid, bus.imem_addr} !== {2'b10, 16'h0004}) begin
      $display("FAIL backpressure_release: got req/val=%b addr=%h, expected 10 addr=0004",
               {bus.imem_req, bus.instr_valid}, bus.imem_addr);
    end else passed++;
  endtask

  task automatic test_halt();
    int bad = 0;
    serve(0, 16'hF000);
    retire(16'h0010, 1'b1);
    total++;
    if ({bus.imem_req, bus.instr_valid, bus.err, bus.PC} !== {3'b000, 16'h0010}) begin
      $display("FAIL halt_enter: got req/val/err=%b PC=%h, expected 000 PC=0010",
               {bus.imem_req, bus.instr_valid, bus.err}, bus.PC);
    end else passed++;
    for (int k = 0; k < 20; k++) begin
      bus.imem_ack = 1'($urandom);
      bus.instr_ready = 1'($urandom);
      bus.halt = 1'($urandom);
      bus.PC_nxt = 16'($urandom);
      tick();
      if ({bus.imem_req, bus.instr_valid, bus.err, bus.PC} !== {3'b000, 16'h0010}) bad++;
    end
    total++;
    if (bad != 0) begin
      $display("FAIL halt_hold: got %0d bad cycles of 20, expected 0", bad);
    end else passed++;
    do_reset();
    tick();
    total++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, RESET_PC}) begin
      $display("FAIL halt_restart: got req=%b addr=%h, expected 1 addr=%h",
               bus.imem_req, bus.imem_addr, RESET_PC);
    end else passed++;
  endtask

  task automatic test_misalign();
    serve(1, 16'h1234);
    retire(16'h0005, 1'b0);
    total++;
    if ({bus.imem_req, bus.instr_valid, bus.err, bus.PC} !== {3'b001, 16'h0005}) begin
      $display("FAIL misalign_err: got req/val/err=%b PC=%h, expected 001 PC=0005",
               {bus.imem_req, bus.instr_valid, bus.err}, bus.PC);
    end else passed++;
    for (int k = 0; k < 4; k++) begin
      bus.imem_ack = 1'($urandom);
      bus.instr_ready = 1'($urandom);
      tick();
    end
    total++;
    if ({bus.imem_req, bus.instr_valid, bus.err, bus.PC} !== {3'b001, 16'h0005}) begin
      $display("FAIL misalign_sticky: got req/val/err=%b PC=%h, expected 001 PC=0005",
               {bus.imem_req, bus.instr_valid, bus.err}, bus.PC);
    end else passed++;
    do_reset();
    tick();
    serve(0, 16'h5678);
    retire(16'h0005, 1'b1);
    tick();
    total++;
    if ({bus.imem_req, bus.instr_valid, bus.err, bus.PC} !== {3'b000, 16'h0005}) begin
      $display("FAIL halt_over_misalign: got req/val/err=%b PC=%h, expected 000 PC=0005",
               {bus.imem_req, bus.instr_valid, bus.err}, bus.PC);
    end else passed++;
  endtask

  task automatic test_timeout();
    int bad = 0;
    logic [15:0] d;
    do_reset();
    tick();
    // Wait cycles 1..TIMEOUT+1 stay error-free; err follows the last one.
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      if ({bus.imem_req, bus.err, bus.imem_addr} !== {2'b10, RESET_PC}) bad++;
      tick();
    end
    total++;
    if (bad != 0) begin
      $display("FAIL timeout_wait: got %0d bad wait cycles, expected 0", bad);
    end else passed++;
    total++;
    if ({bus.imem_req, bus.instr_valid, bus.err} !== 3'b001) begin
      $display("FAIL timeout_err: got req/val/err=%b, expected 001",
               {bus.imem_req, bus.instr_valid, bus.err});
    end else passed++;

    do_reset();
    tick();
    for (int k = 1; k < 8; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({bus.imem_req, bus.err} !== 2'b00) begin
      $display("FAIL midwait_reset: got req/err=%b, expected 00", {bus.imem_req, bus.err});
    end else passed++;
    tick();
    bad = 0;
    d = 16'($urandom);
    for (int k = 1; k <= TIMEOUT; k++) begin
      if ({bus.imem_req, bus.err, bus.imem_addr} !== {2'b10, RESET_PC}) bad++;
      if (k == TIMEOUT) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = d;
      end
      tick();
      bus.imem_ack = 1'b0;
    end
    total++;
    if (bad != 0 || {bus.instr_valid, bus.err, bus.instr} !== {2'b10, d}) begin
      $display("FAIL late_ack: got %0d bad waits val/err=%b instr=%h, expected 0 10 instr=%h",
               bad, {bus.instr_valid, bus.err}, bus.instr, d);
    end else passed++;
  endtask

  // Model: a stream of fetch transactions; each is addressed by the model's PC,
  // delivers its data after random latency, and hands the model the next PC.
  task automatic test_random_stream();
    logic [15:0] pc, d, nxt;
    int lat, bp;
    do_reset();
    tick();
    pc = RESET_PC;
    for (int t = 0; t < 40; t++) begin
      lat = $urandom_range(0, 6);
      bp  = $urandom_range(0, 3);
      d   = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       nxt = 16'($urandom) & 16'hFFFE;
        1:       nxt = 16'hFFFE;
        default: nxt = pc + 16'd2;
      endcase
      for (int k = 0; k <= lat; k++) begin
        total++;
        if ({bus.imem_req, bus.instr_valid, bus.err, bus.imem_addr} !== {3'b100, pc}) begin
          $display("FAIL stream_req[%0d.%0d]: got req/val/err=%b addr=%h, expected 100 addr=%h",
                   t, k, {bus.imem_req, bus.instr_valid, bus.err}, bus.imem_addr, pc);
        end else passed++;
        bus.instr_ready = 1'($urandom);
        bus.halt = 1'($urandom);
        bus.imem_ack = (k == lat);
        bus.imem_rdata = (k == lat) ? d : 16'($urandom);
        tick();
      end
      bus.imem_ack = 1'b0;
      bus.halt = 1'b0;
      for (int b = 0; b <= bp; b++) begin
        total++;
        if ({bus.imem_req, bus.instr_valid, bus.err, bus.instr, bus.PC} !== {3'b010, d, pc}) begin
          $display("FAIL stream_valid[%0d.%0d]: got req/val/err=%b instr=%h PC=%h, expected 010 %h %h",
                   t, b, {bus.imem_req, bus.instr_valid, bus.err}, bus.instr, bus.PC, d, pc);
        end else passed++;
        if (b < bp) begin
          bus.instr_ready = 1'b0;
          tick();
        end
      end
      retire(nxt, 1'b0);
      pc = nxt;
    end
  endtask

  initial begin
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0000;
    bus.instr_ready = 1'b0;
    bus.PC_nxt      = 16'h0000;
    bus.halt        = 1'b0;
    test_reset();
    test_min_latency();
    test_latency3();
    test_backpressure();
    test_halt();
    test_misalign();
    test_timeout();
    test_random_stream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
